// File: rtl/ddpuf_pkg.sv
// Shared types and constants for the DD-PUF measurement sequencer.
package ddpuf_pkg;

    // Default response width; matches the span of the SPI PUF register.
    localparam int PUF_W_DEF  = 128;

    // Cycles spent in SAMPLE; two so the 2-flop synchronizer is flushed.
    localparam int SAMPLE_CYC = 2;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_GAP,
        ST_DONE
    } meas_state_t;

endpackage

// File: rtl/ddpuf_vote_acc.sv
// Synchronizes the raw cell responses and keeps a per-bit count of ones
// across the measurement rounds; the majority output also counts the bit
// being accumulated this cycle, so the voted word is ready on the same edge
// as the final accumulate.
module ddpuf_vote_acc
    import ddpuf_pkg::*;
#(
    parameter int PUF_W = PUF_W_DEF,
    parameter int VOTES = 3
) (
    input  logic             SCLK,
    input  logic             RST_N,
    input  logic [PUF_W-1:0] resp_async,
    input  logic             clear,
    input  logic             accumulate,
    output logic [PUF_W-1:0] majority
);

    localparam int CW = $clog2(VOTES + 1);

    logic [PUF_W-1:0] sync1;
    logic [PUF_W-1:0] sync2;
    logic [CW-1:0]    ones [PUF_W];

    // Two-flop synchronizer bringing the asynchronous cell outputs into SCLK.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= resp_async;
            sync2 <= sync1;
        end
    end

    // Per-bit ones counters: cleared at measurement start, bumped once per round.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < PUF_W; i++) begin
                ones[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < PUF_W; i++) begin
                ones[i] <= '0;
            end
        end else if (accumulate) begin
            for (int i = 0; i < PUF_W; i++) begin
                ones[i] <= ones[i] + CW'(sync2[i]);
            end
        end
    end

    // Majority vote including any bit being accumulated in this cycle.
    always_comb begin
        majority = '0;
        for (int i = 0; i < PUF_W; i++) begin
            majority[i] = ((ones[i] + CW'(accumulate & sync2[i])) > CW'(VOTES / 2));
        end
    end

endmodule

// File: rtl/ddpuf_meas_ctrl.sv
// DD-PUF measurement sequencer: on a rising FSM_Start it runs VOTES
// excite/sample rounds on the cell array, majority-votes each response bit
// and returns the result on PUF_Val with the FSM_Complete handshake.
module ddpuf_meas_ctrl
    import ddpuf_pkg::*;
#(
    parameter int PUF_W = PUF_W_DEF,
    parameter int VOTES = 3,
    parameter int GAP   = 4
) (
    input  logic             SCLK,
    input  logic             RST_N,
    input  logic             FSM_Start,
    input  logic [15:0]      Duration,
    output logic             FSM_Complete,
    output logic [PUF_W-1:0] PUF_Val,
    output logic             PUF_EN,
    input  logic [PUF_W-1:0] PUF_RESP,
    output logic             BUSY
);

    localparam int RW = $clog2(VOTES + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int SW = $clog2(SAMPLE_CYC);

    meas_state_t      state;
    meas_state_t      next_state;
    logic             start_q;
    logic             start_edge;
    logic [15:0]      dur_load;
    logic [15:0]      dur_q;
    logic [15:0]      settle_cnt;
    logic [SW-1:0]    sample_cnt;
    logic [RW-1:0]    round_q;
    logic [GW-1:0]    gap_cnt;
    logic             acc_clear;
    logic             acc_add;
    logic [PUF_W-1:0] vote_bits;

    assign start_edge = FSM_Start & ~start_q;
    assign dur_load   = (Duration == 16'd0) ? 16'd1 : Duration;

    ddpuf_vote_acc #(
        .PUF_W(PUF_W),
        .VOTES(VOTES)
    ) u_vote_acc (
        .SCLK      (SCLK),
        .RST_N     (RST_N),
        .resp_async(PUF_RESP),
        .clear     (acc_clear),
        .accumulate(acc_add),
        .majority  (vote_bits)
    );

    // State register.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; dropping FSM_Start anywhere mid-run aborts to IDLE.
    always_comb begin
        next_state = state;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    next_state = ST_SETTLE;
                    acc_clear  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!FSM_Start) begin
                    next_state = ST_IDLE;
                end else if (settle_cnt == 16'd1) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!FSM_Start) begin
                    next_state = ST_IDLE;
                end else if (sample_cnt == SW'(SAMPLE_CYC - 1)) begin
                    acc_add    = 1'b1;
                    next_state = (round_q == RW'(VOTES - 1)) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (!FSM_Start) begin
                    next_state = ST_IDLE;
                end else if (gap_cnt == GW'(1)) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (!FSM_Start) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Edge detector, latched duration and the settle/sample/gap/round counters.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            start_q    <= 1'b0;
            dur_q      <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            round_q    <= '0;
            gap_cnt    <= '0;
        end else begin
            start_q <= FSM_Start;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        dur_q      <= dur_load;
                        settle_cnt <= dur_load;
                        sample_cnt <= '0;
                        round_q    <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != 16'd1) begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (acc_add) begin
                        sample_cnt <= '0;
                        round_q    <= round_q + RW'(1);
                        gap_cnt    <= GW'(GAP);
                    end else begin
                        sample_cnt <= sample_cnt + SW'(1);
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        settle_cnt <= dur_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs decoded from the upcoming state; PUF_Val only
    // changes when a full set of rounds completes, so aborts keep the old value.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            FSM_Complete <= 1'b0;
            PUF_Val      <= '0;
            PUF_EN       <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            FSM_Complete <= (next_state == ST_DONE);
            PUF_EN       <= (next_state == ST_SETTLE) || (next_state == ST_SAMPLE);
            BUSY         <= (next_state == ST_SETTLE) || (next_state == ST_SAMPLE) ||
                            (next_state == ST_GAP);
            if ((state == ST_SAMPLE) && (next_state == ST_DONE)) begin
                PUF_Val <= vote_bits;
            end
        end
    end

endmodule

// File: tb/tb_ddpuf_meas_ctrl.sv
// Self-checking bench for ddpuf_meas_ctrl: per-round responses are chosen by
// the bench, the expected schedule and voted word come from plain arithmetic.
module tb_ddpuf_meas_ctrl;

    localparam int W        = 128;
    localparam int VOTE_CNT = 3;
    localparam int GAP_CYC  = 4;
    localparam logic [W-1:0] NOMINAL = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [W-1:0] PATTERN = {16{8'hA5}};

    logic          SCLK;
    logic          RST_N;
    logic          FSM_Start;
    logic [15:0]   Duration;
    logic          FSM_Complete;
    logic [W-1:0]  PUF_Val;
    logic          PUF_EN;
    logic [W-1:0]  PUF_RESP;
    logic          BUSY;

    int            check_count;
    int            pass_count;
    logic [W-1:0]  exp_val;
    logic [W-1:0]  round_resp [VOTE_CNT];

    ddpuf_meas_ctrl #(
        .PUF_W(W),
        .VOTES(VOTE_CNT),
        .GAP  (GAP_CYC)
    ) dut (
        .SCLK        (SCLK),
        .RST_N       (RST_N),
        .FSM_Start   (FSM_Start),
        .Duration    (Duration),
        .FSM_Complete(FSM_Complete),
        .PUF_Val     (PUF_Val),
        .PUF_EN      (PUF_EN),
        .PUF_RESP    (PUF_RESP),
        .BUSY        (BUSY)
    );

    // Free-running clock.
    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Majority of the per-round responses, bit by bit.
    function automatic logic [W-1:0] voteModel();
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < W; i++) begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < VOTE_CNT; k++) begin
                cnt += int'(round_resp[k][i]);
            end
            res[i] = (2 * cnt > VOTE_CNT);
        end
        return res;
    endfunction

    function automatic logic [W-1:0] randWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic randomRounds();
        for (int k = 0; k < VOTE_CNT; k++) begin
            round_resp[k] = randWord();
        end
    endtask

    // One measurement: raise FSM_Start, follow the expected schedule cycle by
    // cycle, optionally abort by dropping FSM_Start at cycle abort_at, else
    // hold FSM_Start for hold_cyc cycles after completion and release it.
    task automatic applyStimulus(input int dur_in, input int hold_cyc, input int abort_at);
        int d;
        int period;
        int lat;
        bit aborted;
        d       = (dur_in == 0) ? 1 : dur_in;
        period  = d + 2 + GAP_CYC;
        lat     = VOTE_CNT * (d + 2) + (VOTE_CNT - 1) * GAP_CYC + 1;
        aborted = 1'b0;
        @(negedge SCLK);
        FSM_Start = 1'b1;
        Duration  = 16'(dur_in);
        PUF_RESP  = round_resp[0];
        for (int c = 1; c <= lat; c++) begin
            int r;
            int pos;
            @(negedge SCLK);
            r   = (c - 1) / period;
            pos = (c - 1) % period;
            if (abort_at != 0 && c == abort_at + 1) begin
                checkOutput("abort_en", PUF_EN, 1'b0);
                checkOutput("abort_busy", BUSY, 1'b0);
                checkOutput("abort_cmpl", FSM_Complete, 1'b0);
                checkOutput("abort_val", PUF_Val, exp_val);
                aborted = 1'b1;
                break;
            end
            if (c < lat) begin
                checkOutput($sformatf("en_c%0d", c), PUF_EN, (pos < d + 2));
                checkOutput($sformatf("busy_c%0d", c), BUSY, 1'b1);
                checkOutput($sformatf("cmpl_c%0d", c), FSM_Complete, 1'b0);
            end else begin
                exp_val = voteModel();
                checkOutput("done_cmpl", FSM_Complete, 1'b1);
                checkOutput("done_en", PUF_EN, 1'b0);
                checkOutput("done_busy", BUSY, 1'b0);
                checkOutput("done_val", PUF_Val, exp_val);
            end
            if (pos == d + 2 && r + 1 < VOTE_CNT) begin
                PUF_RESP = round_resp[r + 1];
                Duration = 16'($urandom);
            end
            if (abort_at != 0 && c == abort_at) begin
                FSM_Start = 1'b0;
            end
        end
        if (aborted) begin
            repeat (5) begin
                @(negedge SCLK);
                checkOutput("post_abort_cmpl", FSM_Complete, 1'b0);
                checkOutput("post_abort_val", PUF_Val, exp_val);
            end
        end else begin
            repeat (hold_cyc) begin
                @(negedge SCLK);
                checkOutput("hold_cmpl", FSM_Complete, 1'b1);
                checkOutput("hold_en", PUF_EN, 1'b0);
            end
            FSM_Start = 1'b0;
            @(negedge SCLK);
            checkOutput("release_cmpl", FSM_Complete, 1'b0);
            checkOutput("release_val", PUF_Val, exp_val);
            repeat (2) begin
                @(negedge SCLK);
                checkOutput("no_retrig_busy", BUSY, 1'b0);
                checkOutput("no_retrig_cmpl", FSM_Complete, 1'b0);
            end
        end
    endtask

    // Main sequence.
    initial begin
        check_count = 0;
        pass_count  = 0;
        exp_val     = '0;
        RST_N       = 1'b0;
        FSM_Start   = 1'b0;
        Duration    = '0;
        PUF_RESP    = '0;
        repeat (3) @(negedge SCLK);
        checkOutput("rst_cmpl", FSM_Complete, 1'b0);
        checkOutput("rst_val", PUF_Val, '0);
        checkOutput("rst_en", PUF_EN, 1'b0);
        checkOutput("rst_busy", BUSY, 1'b0);
        RST_N = 1'b1;
        repeat (2) @(negedge SCLK);

        $display("[TB] nominal run");
        for (int k = 0; k < VOTE_CNT; k++) round_resp[k] = NOMINAL;
        applyStimulus(10, 20, 0);
        checkOutput("nominal_val", PUF_Val, NOMINAL);

        $display("[TB] majority run");
        randomRounds();
        round_resp[0][1:0] = 2'b01;
        round_resp[1][1:0] = 2'b00;
        round_resp[2][1:0] = 2'b11;
        applyStimulus(3, 2, 0);
        checkOutput("maj_bit0", PUF_Val[0], 1'b1);
        checkOutput("maj_bit1", PUF_Val[1], 1'b0);

        $display("[TB] zero duration run");
        randomRounds();
        applyStimulus(0, 1, 0);

        $display("[TB] abort in second gap");
        randomRounds();
        applyStimulus(5, 1, 11 + 5 + 4);
        randomRounds();
        applyStimulus(5, 3, 0);

        $display("[TB] randomized runs");
        for (int n = 0; n < 8; n++) begin
            randomRounds();
            applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)), 0);
        end

        $display("[TB] reset mid-settle");
        for (int k = 0; k < VOTE_CNT; k++) round_resp[k] = PATTERN;
        applyStimulus(4, 1, 0);
        checkOutput("pattern_val", PUF_Val, PATTERN);
        @(negedge SCLK);
        FSM_Start = 1'b1;
        Duration  = 16'd10;
        repeat (4) @(negedge SCLK);
        checkOutput("pre_rst_en", PUF_EN, 1'b1);
        RST_N = 1'b0;
        #1;
        checkOutput("mid_rst_cmpl", FSM_Complete, 1'b0);
        checkOutput("mid_rst_val", PUF_Val, '0);
        checkOutput("mid_rst_en", PUF_EN, 1'b0);
        checkOutput("mid_rst_busy", BUSY, 1'b0);
        FSM_Start = 1'b0;
        repeat (2) @(negedge SCLK);
        RST_N   = 1'b1;
        exp_val = '0;
        @(negedge SCLK);
        checkOutput("post_rst_cmpl", FSM_Complete, 1'b0);
        randomRounds();
        applyStimulus(2, 0, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_count, check_count + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
